// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage for op_mne-encoded ALU operations.
// Takes {op, a, b} from decode over a valid/ready handshake and returns a
// registered result with zero/carry/illegal flags. All ops complete in one
// cycle except LSH, which shifts one bit per cycle for in_b[SHW-1:0] cycles.
// The output register drains and reloads on the same edge, so back-to-back
// single-cycle ops sustain one result per cycle.
//
// op_mne encoding (matches the Definitions package ordering):
//   0 NOP   1 INC   2 DEC   3 CLB   4 ADD   5 SUB   6 ORR    7 AND
//   8 XOR   9 LSH  10 RXOR_7  11 RXOR_8  12..15 illegal

module alu_exec_unit #(
  parameter int W   = 8,  // datapath width, RXOR_7/RXOR_8 need W >= 8
  parameter int SHW = 3   // LSH count width taken from in_b[SHW-1:0]
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_carry,
  output logic         out_illegal,
  output logic         busy
);

  // op_mne codes
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_CLB   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_ORR   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_LSH   = 4'd9;
  localparam logic [3:0] OP_RXOR7 = 4'd10;
  localparam logic [3:0] OP_RXOR8 = 4'd11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Zero flag helper shared by the single-cycle and shift completion paths.
  function automatic logic zero_flag(input logic [W-1:0] v);
    return (v == {W{1'b0}});
  endfunction

  // Architectural state
  state_e         state_q;
  logic [W-1:0]   acc_q;
  logic [SHW-1:0] cnt_q;
  logic           out_valid_q;
  logic [W-1:0]   out_result_q;
  logic           out_zero_q;
  logic           out_carry_q;
  logic           out_illegal_q;
  logic           busy_q;

  // Combinational datapath
  logic [W:0]     add_s;
  logic [W:0]     sub_s;
  logic [W:0]     inc_s;
  logic [W-1:0]   dec_s;
  logic [SHW-1:0] shift_cnt_s;
  logic           start_shift_s;
  logic           in_ready_s;
  logic           accept_s;
  logic [W-1:0]   alu_res_s;
  logic           alu_carry_s;
  logic           alu_illegal_s;
  logic [W-1:0]   acc_shl_s;

  // The extra top bit of the widened add/sub/inc holds carry-out or borrow.
  assign add_s = {1'b0, in_a} + {1'b0, in_b};
  assign sub_s = {1'b0, in_a} - {1'b0, in_b};
  assign inc_s = {1'b0, in_a} + {{W{1'b0}}, 1'b1};
  assign dec_s = in_a - {{(W-1){1'b0}}, 1'b1};

  assign shift_cnt_s   = in_b[SHW-1:0];
  assign start_shift_s = (in_op == OP_LSH) && (shift_cnt_s != {SHW{1'b0}});

  // Ready ignores in_valid so upstream can use it without a combinational loop.
  assign in_ready_s = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !reset;
  assign accept_s   = in_valid && in_ready_s;

  assign acc_shl_s = {acc_q[W-2:0], 1'b0};

  // Single-cycle result and flags for the op presented on the input port.
  always_comb begin
    alu_res_s     = {W{1'b0}};
    alu_carry_s   = 1'b0;
    alu_illegal_s = 1'b0;
    case (in_op)
      OP_NOP: alu_res_s = in_a;
      OP_INC: begin
        alu_res_s   = inc_s[W-1:0];
        alu_carry_s = inc_s[W];
      end
      OP_DEC: begin
        alu_res_s   = dec_s;
        alu_carry_s = (in_a == {W{1'b0}});
      end
      OP_CLB: begin
        alu_res_s        = in_a;
        alu_res_s[W-1]   = 1'b0;
      end
      OP_ADD: begin
        alu_res_s   = add_s[W-1:0];
        alu_carry_s = add_s[W];
      end
      OP_SUB: begin
        alu_res_s   = sub_s[W-1:0];
        alu_carry_s = sub_s[W];
      end
      OP_ORR:   alu_res_s = in_a | in_b;
      OP_AND:   alu_res_s = in_a & in_b;
      OP_XOR:   alu_res_s = in_a ^ in_b;
      // Only the count==0 case completes here; nonzero counts go to SHIFT.
      OP_LSH:   alu_res_s = in_a;
      OP_RXOR7: alu_res_s[0] = ^in_a[6:0];
      OP_RXOR8: alu_res_s[0] = ^in_a[7:0];
      default: begin
        alu_res_s     = {W{1'b0}};
        alu_illegal_s = 1'b1;
      end
    endcase
  end

  // Control FSM plus output register: accept, iterate LSH, hold under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      acc_q         <= {W{1'b0}};
      cnt_q         <= {SHW{1'b0}};
      out_valid_q   <= 1'b0;
      out_result_q  <= {W{1'b0}};
      out_zero_q    <= 1'b0;
      out_carry_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (start_shift_s) begin
              // Output slot is free (or drains this edge); nothing to show until done.
              acc_q       <= in_a;
              cnt_q       <= shift_cnt_s;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              state_q     <= S_SHIFT;
            end else begin
              out_valid_q   <= 1'b1;
              out_result_q  <= alu_res_s;
              out_zero_q    <= zero_flag(alu_res_s);
              out_carry_q   <= alu_carry_s;
              out_illegal_q <= alu_illegal_s;
            end
          end else if (out_ready) begin
            // Consumed with no replacement: drop valid, keep last data.
            out_valid_q <= 1'b0;
          end else begin
            // Stalled or empty: every output holds.
            out_valid_q <= out_valid_q;
          end
        end
        S_SHIFT: begin
          // The carry is the bit shifted out on the final step, so it is
          // taken straight from acc_q[W-1] when the last shift completes.
          acc_q <= acc_shl_s;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= acc_shl_s;
            out_zero_q    <= zero_flag(acc_shl_s);
            out_carry_q   <= acc_q[W-1];
            out_illegal_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_carry   = out_carry_q;
  assign out_illegal = out_illegal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes the expected result
// of every accepted op, a negedge monitor pops on every consumed result.
module tb_alu_exec_unit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_carry;
  logic       out_illegal;
  logic       busy;

  alu_exec_unit #(.W(8), .SHW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_carry   (out_carry),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       il;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_rdy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ai = a;
    int bi = b;
    int r = 0;
    int n;
    bit c = 0;
    bit il = 0;
    logic [6:0] lo7;
    lo7 = a[6:0];
    case (op)
      4'd0: r = ai;
      4'd1: begin r = ai + 1; c = (r > 255); end
      4'd2: begin r = ai - 1; c = (ai == 0); end
      4'd3: r = ai % 128;
      4'd4: begin r = ai + bi; c = (r > 255); end
      4'd5: begin r = ai - bi; c = (ai < bi); end
      4'd6: r = ai | bi;
      4'd7: r = ai & bi;
      4'd8: r = ai ^ bi;
      4'd9: begin
        n = bi % 8;
        r = ai * (1 << n);
        if (n > 0) c = ((ai >> (8 - n)) % 2) == 1;
      end
      4'd10: r = $countones(lo7) % 2;
      4'd11: r = $countones(a) % 2;
      default: begin r = 0; il = 1; end
    endcase
    r = r & 255;
    e.r  = r[7:0];
    e.z  = (r == 0);
    e.c  = c;
    e.il = il;
    return e;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present an op and hold it until accepted (bounded); expectation pushed on accept.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    forever begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b));
        break;
      end
      t++;
      if (t > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Randomised downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on each consumed result, checks stability while stalled.
  exp_t held;
  bit   hold_pend = 0;
  always @(negedge clk) begin
    exp_t got;
    got = {out_result, out_zero, out_carry, out_illegal};
    if (reset) begin
      hold_pend = 0;
    end else begin
      if (busy && in_ready) check("ready_while_busy", 1, 0);
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", got, held);
      end
      hold_pend = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) check("unexpected_result", got, 0);
          else check("result", got, sb.pop_front());
        end else begin
          hold_pend = 1;
          held = got;
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    in_op = 4'd0;
    in_a = 8'd0;
    in_b = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_flags", {out_result, out_zero, out_carry, out_illegal}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors from the op table, back to back.
    issue(4'd4, 8'hF0, 8'h20);
    check("add_latency1", out_valid, 1);
    issue(4'd1, 8'hFF, 8'h00);
    issue(4'd2, 8'h00, 8'h00);
    issue(4'd3, 8'hFF, 8'h00);
    issue(4'd5, 8'h05, 8'h05);
    issue(4'd5, 8'h03, 8'h05);
    issue(4'd10, 8'h83, 8'h00);
    issue(4'd11, 8'h83, 8'h00);
    issue(4'd12, 8'h55, 8'hAA);
    issue(4'd15, 8'h01, 8'h02);
    issue(4'd6, 8'hA0, 8'h05);
    issue(4'd7, 8'hF0, 8'h3C);
    issue(4'd8, 8'hFF, 8'h0F);
    issue(4'd0, 8'h00, 8'h00);
    drain();

    // LSH count 3: busy for exactly 3 cycles.
    issue(4'd9, 8'h81, 8'h03);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("lsh3_busy_cycles", n, 3);
    check("lsh3_valid_after", out_valid, 1);
    issue(4'd9, 8'h81, 8'h01);
    drain();
    // Count 0 (upper bits of b ignored) behaves as single-cycle pass-through.
    issue(4'd9, 8'h81, 8'h08);
    check("lsh0_latency1", out_valid, 1);
    check("lsh0_busy", busy, 0);
    drain();

    // Backpressure: result stalls, next op waits, then drain and load together.
    out_ready = 1'b0;
    issue(4'd4, 8'h11, 8'h22);
    in_valid = 1'b1;
    in_op = 4'd5;
    in_a = 8'h10;
    in_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(4'd5, 8'h10, 8'h01);
    check("bp_new_valid", out_valid, 1);
    drain();

    // Reset two cycles into a long shift discards it.
    issue(4'd9, 8'h81, 8'h07);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1);
    issue(4'd4, 8'h01, 8'h01);
    drain();

    // Random ops with random gaps and random backpressure.
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = (i % 7 == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      issue(op, 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
